// File: rtl/mm_pkg.sv
// Shared state encoding and default widths for the matrix-multiplication datapath.
package mm_pkg;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } mac_state_e;

   localparam int MM_DATA_W = 8;
   localparam int MM_ACC_W  = 20;

endpackage

// File: rtl/dot_product_mac_if.sv
// Operand-in / result-out handshake bundle for the dot-product MAC stage.
interface dot_product_mac_if
   import mm_pkg::*;
#(
   parameter int DATA_W = MM_DATA_W,
   parameter int ACC_W  = MM_ACC_W
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic              out_ovf;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_sum, out_ovf
   );

endinterface

// File: rtl/mac_adder.sv
// W-bit ripple-carry adder used on the accumulate path; carry-out feeds overflow detection.
module mac_adder #(
   parameter int W = 20
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] sum,
   output logic         cout
);

   always_comb begin
      logic w_carry;
      w_carry = 1'b0;
      sum     = '0;
      for (int i = 0; i < W; i++) begin
         sum[i]  = x[i] ^ y[i] ^ w_carry;
         w_carry = (x[i] & y[i]) | (w_carry & (x[i] ^ y[i]));
      end
      cout = w_carry;
   end

endmodule

// File: rtl/dot_product_mac.sv
// Sequential MAC: accumulates K unsigned products, then holds the sum until the result handshake.
// Build option MAC_SATURATE_EN: clamp the accumulator on carry-out and flag out_ovf (default: wrap).
module dot_product_mac
   import mm_pkg::*;
#(
   parameter int DATA_W = MM_DATA_W,
   parameter int ACC_W  = MM_ACC_W,
   parameter int K      = 4
) (
   input  logic            clk,
   input  logic            rst,
   dot_product_mac_if.slave bus
);

   localparam int              CNT_W    = (K > 1) ? $clog2(K) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

   mac_state_e         r_state;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf;
   logic               r_in_ready;
   logic               r_out_valid;

   logic [2*DATA_W-1:0] w_prod_full;
   logic [ACC_W-1:0]    w_prod;
   logic [ACC_W-1:0]    w_sum;
   logic [ACC_W-1:0]    w_acc_next;
   logic                w_cout;
   logic                w_ovf_set;

   assign w_prod_full = {{DATA_W{1'b0}}, bus.in_a} * {{DATA_W{1'b0}}, bus.in_b};
   assign w_prod      = ACC_W'(w_prod_full);

   mac_adder #(.W(ACC_W)) u_mac_adder (
      .x    (r_acc),
      .y    (w_prod),
      .sum  (w_sum),
      .cout (w_cout)
   );

`ifdef MAC_SATURATE_EN
   // Once clamped the accumulator stays at full scale until the result is taken.
   assign w_acc_next = (w_cout || r_ovf) ? {ACC_W{1'b1}} : w_sum;
   assign w_ovf_set  = w_cout;
`else
   logic w_unused_cout;
   assign w_unused_cout = w_cout;
   assign w_acc_next    = w_sum;
   assign w_ovf_set     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_ACC;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_ACC: begin
               if (bus.in_valid) begin
                  r_acc <= w_acc_next;
                  r_ovf <= r_ovf | w_ovf_set;
                  if (r_cnt == CNT_LAST) begin
                     r_cnt       <= '0;
                     r_state     <= ST_DONE;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  r_acc       <= '0;
                  r_ovf       <= 1'b0;
                  r_state     <= ST_ACC;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: r_state <= ST_ACC;
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_sum   = r_acc;
   assign bus.out_ovf   = r_ovf;

endmodule

// File: tb/tb_dot_product_mac.sv
// Directed bench: drives a 20-bit and a 16-bit accumulator instance in lockstep and scores results.
module tb_dot_product_mac;

   localparam int K = 4;

   typedef struct {
      logic [19:0] sum20;
      logic        ovf20;
      logic [15:0] sum16;
      logic        ovf16;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tb_valid = 1'b0;
   logic [7:0] tb_a = '0;
   logic [7:0] tb_b = '0;
   logic       tb_oready = 1'b0;

   int   n_cmp = 0;
   int   n_err = 0;
   int   n_acc = 0;
   exp_t pend;
   exp_t q[$];

   always #5 clk = ~clk;

   dot_product_mac_if #(.DATA_W(8), .ACC_W(20)) if20 ();
   dot_product_mac_if #(.DATA_W(8), .ACC_W(16)) if16 ();

   assign if20.in_valid  = tb_valid;
   assign if20.in_a      = tb_a;
   assign if20.in_b      = tb_b;
   assign if20.out_ready = tb_oready;
   assign if16.in_valid  = tb_valid;
   assign if16.in_a      = tb_a;
   assign if16.in_b      = tb_b;
   assign if16.out_ready = tb_oready;

   dot_product_mac #(.DATA_W(8), .ACC_W(20), .K(K)) u_dut20 (
      .clk (clk),
      .rst (rst),
      .bus (if20.slave)
   );

   dot_product_mac #(.DATA_W(8), .ACC_W(16), .K(K)) u_dut16 (
      .clk (clk),
      .rst (rst),
      .bus (if16.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; the K-th accepted pair pushes the pending expectation.
   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
      logic rdy;
      tb_valid = v;
      tb_a     = a;
      tb_b     = b;
      rdy      = if20.in_ready;
      @(posedge clk);
      #1;
      if (v && rdy) begin
         n_acc++;
         if (n_acc == K) begin
            n_acc = 0;
            q.push_back(pend);
            check("latency_valid20", {31'd0, if20.out_valid}, 32'd1);
            check("latency_valid16", {31'd0, if16.out_valid}, 32'd1);
         end
      end
   endtask

   // Waits for a result, holds it for 'stall' cycles with garbage on the input side, then takes it.
   task automatic drain(input int stall);
      exp_t e;
      int   t;
      check("sb_has_entry", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) e = q.pop_front();
      else e = '{sum20: '0, ovf20: 1'b0, sum16: '0, ovf16: 1'b0};
      tb_oready = 1'b0;
      t = 0;
      while (!if20.out_valid && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("out_valid_seen", {31'd0, if20.out_valid}, 32'd1);
      tb_valid = 1'b1;
      tb_a     = 8'd50;
      tb_b     = 8'd50;
      repeat (stall) begin
         @(posedge clk);
         #1;
         check("bp_hold_sum20", {12'd0, if20.out_sum}, {12'd0, e.sum20});
         check("bp_in_ready", {31'd0, if20.in_ready}, 32'd0);
         check("bp_out_valid", {31'd0, if20.out_valid}, 32'd1);
      end
      check("sum20", {12'd0, if20.out_sum}, {12'd0, e.sum20});
      check("ovf20", {31'd0, if20.out_ovf}, {31'd0, e.ovf20});
      check("sum16", {16'd0, if16.out_sum}, {16'd0, e.sum16});
      check("ovf16", {31'd0, if16.out_ovf}, {31'd0, e.ovf16});
      tb_oready = 1'b1;
      @(posedge clk);
      #1;
      tb_oready = 1'b0;
      tb_valid  = 1'b0;
      check("post_hs_valid", {31'd0, if20.out_valid}, 32'd0);
      check("post_hs_ready", {31'd0, if20.in_ready}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [6:0] pat;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, if20.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, if20.out_valid}, 32'd0);
      check("rst_out_sum", {12'd0, if20.out_sum}, 32'd0);
      check("rst_out_ovf", {31'd0, if20.out_ovf}, 32'd0);
      check("rst_out_valid16", {31'd0, if16.out_valid}, 32'd0);
      rst = 1'b0;

      // Basic dot product: 1*2 + 3*4 + 5*6 + 7*8 = 100
      pend = '{sum20: 20'd100, ovf20: 1'b0, sum16: 16'd100, ovf16: 1'b0};
      drive(1'b1, 8'd1, 8'd2);
      drive(1'b1, 8'd3, 8'd4);
      drive(1'b1, 8'd5, 8'd6);
      drive(1'b1, 8'd7, 8'd8);
      drain(0);

      // Backpressure for five cycles, then a fresh dot proves the clear
      drive(1'b1, 8'd1, 8'd2);
      drive(1'b1, 8'd3, 8'd4);
      drive(1'b1, 8'd5, 8'd6);
      drive(1'b1, 8'd7, 8'd8);
      drain(5);
      pend = '{sum20: 20'd16, ovf20: 1'b0, sum16: 16'd16, ovf16: 1'b0};
      for (int i = 0; i < 4; i++) drive(1'b1, 8'd2, 8'd2);
      drain(0);

      // Gaps in in_valid: 1,0,0,1,1,0,1
      pend = '{sum20: 20'd400, ovf20: 1'b0, sum16: 16'd400, ovf16: 1'b0};
      pat  = 7'b1011001;
      for (int i = 0; i < 7; i++) begin
         drive(pat[i], 8'd10, 8'd10);
         if (i == 5) check("gap_no_early_valid", {31'd0, if20.out_valid}, 32'd0);
      end
      drain(0);

      // Max operands: exact in 20 bits, overflows 16 bits
`ifdef MAC_SATURATE_EN
      pend = '{sum20: 20'd260100, ovf20: 1'b0, sum16: 16'd65535, ovf16: 1'b1};
`else
      pend = '{sum20: 20'd260100, ovf20: 1'b0, sum16: 16'd63492, ovf16: 1'b0};
`endif
      for (int i = 0; i < 4; i++) drive(1'b1, 8'd255, 8'd255);
      drain(2);

      // Reset in the middle of a dot product discards the partial sum
      drive(1'b1, 8'd9, 8'd9);
      drive(1'b1, 8'd9, 8'd9);
      tb_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_out_valid", {31'd0, if20.out_valid}, 32'd0);
      check("midrst_out_sum", {12'd0, if20.out_sum}, 32'd0);
      check("midrst_in_ready", {31'd0, if20.in_ready}, 32'd1);
      rst   = 1'b0;
      n_acc = 0;
      pend  = '{sum20: 20'd4, ovf20: 1'b0, sum16: 16'd4, ovf16: 1'b0};
      for (int i = 0; i < 4; i++) drive(1'b1, 8'd1, 8'd1);
      drain(0);

      check("sb_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
